// File: rtl/tag_freelist_pkg.sv
// Shared types, sizing helpers and init values for the rename-tag free list.
package tag_freelist_pkg;

    localparam int TAG_W_DEF = 5;

    function automatic int num_tags(input int tag_w);
        return 2 ** tag_w;
    endfunction

    localparam int NUM_TAGS_DEF = num_tags(TAG_W_DEF);

    typedef logic [TAG_W_DEF-1:0] tag_t;
    typedef logic [TAG_W_DEF:0]   cnt_t;

    // Reset and flush both load slot i with tag i, giving a full in-order list.
    function automatic int unsigned init_tag(input int unsigned idx);
        return idx;
    endfunction

endpackage

// File: rtl/tag_freelist_wrctl.sv
// Two-port retire acceptance: port 0 has priority, drops set the error pulse.
// With TAG_FREELIST_DUPCHK_EN, retires of tags not currently allocated are refused.
module tag_freelist_wrctl
    import tag_freelist_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic [TAG_W:0]            i_count,
    input  logic [TAG_W-1:0]          i_widx,
    input  logic [TAG_W-1:0]          i_tag0,
    input  logic                      i_valid0,
    input  logic [TAG_W-1:0]          i_tag1,
    input  logic                      i_valid1,
`ifdef TAG_FREELIST_DUPCHK_EN
    input  logic [(2**TAG_W)-1:0]     i_in_use,
`endif
    output logic [1:0]                o_ret_acc,
    output logic                      o_we_a,
    output logic                      o_we_b,
    output logic [TAG_W-1:0]          o_waddr_a,
    output logic [TAG_W-1:0]          o_waddr_b,
    output logic [TAG_W-1:0]          o_wdata_a,
    output logic [TAG_W-1:0]          o_wdata_b,
    output logic                      o_drop
);

    localparam int              NUM_TAGS = num_tags(TAG_W);
    localparam logic [TAG_W:0]  FULL_CNT = (TAG_W+1)'(NUM_TAGS);
    localparam logic [TAG_W:0]  ONE_CNT  = (TAG_W+1)'(1);
    localparam logic [TAG_W:0]  TWO_CNT  = (TAG_W+1)'(2);

    logic [TAG_W:0] w_space;
    logic           w_v0;
    logic           w_v1;
    logic           w_acc0;
    logic           w_acc1;

    always_comb begin
        w_space = FULL_CNT - i_count;
`ifdef TAG_FREELIST_DUPCHK_EN
        // A same-tag pair in one cycle can only be freed once; port 1 loses.
        w_v0 = i_valid0 & i_in_use[i_tag0];
        w_v1 = i_valid1 & i_in_use[i_tag1] & ~(i_valid0 & (i_tag0 == i_tag1));
`else
        w_v0 = i_valid0;
        w_v1 = i_valid1;
`endif
        w_acc0    = w_v0 & (w_space != '0);
        w_acc1    = w_v1 & (w_space >= (w_acc0 ? TWO_CNT : ONE_CNT));
        o_we_a    = w_acc0 | w_acc1;
        o_we_b    = w_acc0 & w_acc1;
        o_waddr_a = i_widx;
        o_waddr_b = i_widx + TAG_W'(1);
        o_wdata_a = w_acc0 ? i_tag0 : i_tag1;
        o_wdata_b = i_tag1;
        o_ret_acc = {1'b0, w_acc0} + {1'b0, w_acc1};
        o_drop    = (i_valid0 & ~w_acc0) | (i_valid1 & ~w_acc1);
    end

endmodule

// File: rtl/tag_freelist.sv
// Rename-tag free list: dispatch reads tags, two retire ports return them, flush refills.
// Optional double-free detection is enabled by defining TAG_FREELIST_DUPCHK_EN.
module tag_freelist
    import tag_freelist_pkg::*;
#(
    parameter int TAG_W         = TAG_W_DEF,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Flush,
    input  logic              Rd_en,
    output logic [TAG_W-1:0]  Tag_Out,
    output logic              Tag_Valid,
    input  logic [TAG_W-1:0]  RB_Tag0,
    input  logic              RB_Tag0_Valid,
    input  logic [TAG_W-1:0]  RB_Tag1,
    input  logic              RB_Tag1_Valid,
    output logic              tagFifo_full,
    output logic              tagFifo_empty,
    output logic              tagFifo_aempty,
    output logic [TAG_W:0]    tagFifo_count,
    output logic              tagFifo_err
);

    localparam int              NUM_TAGS = num_tags(TAG_W);
    localparam logic [TAG_W:0]  FULL_CNT = (TAG_W+1)'(NUM_TAGS);
    localparam logic [TAG_W:0]  AE_CNT   = (TAG_W+1)'(AEMPTY_THRESH);

    logic [TAG_W-1:0] r_mem [NUM_TAGS];
    logic [TAG_W:0]   r_rptr;
    logic [TAG_W:0]   r_wptr;
    logic [TAG_W:0]   r_count;
    logic             r_err;

    logic             w_rd_acc;
    logic [1:0]       w_ret_acc;
    logic             w_we_a;
    logic             w_we_b;
    logic [TAG_W-1:0] w_waddr_a;
    logic [TAG_W-1:0] w_waddr_b;
    logic [TAG_W-1:0] w_wdata_a;
    logic [TAG_W-1:0] w_wdata_b;
    logic             w_drop;

`ifdef TAG_FREELIST_DUPCHK_EN
    logic [NUM_TAGS-1:0] r_in_use;
`endif

    assign w_rd_acc = Rd_en & (r_count != '0);

    tag_freelist_wrctl #(.TAG_W(TAG_W)) u_wrctl (
        .i_count   (r_count),
        .i_widx    (r_wptr[TAG_W-1:0]),
        .i_tag0    (RB_Tag0),
        .i_valid0  (RB_Tag0_Valid),
        .i_tag1    (RB_Tag1),
        .i_valid1  (RB_Tag1_Valid),
`ifdef TAG_FREELIST_DUPCHK_EN
        .i_in_use  (r_in_use),
`endif
        .o_ret_acc (w_ret_acc),
        .o_we_a    (w_we_a),
        .o_we_b    (w_we_b),
        .o_waddr_a (w_waddr_a),
        .o_waddr_b (w_waddr_b),
        .o_wdata_a (w_wdata_a),
        .o_wdata_b (w_wdata_b),
        .o_drop    (w_drop)
    );

    always_ff @(posedge clock) begin
        if (reset || Flush) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                r_mem[i] <= TAG_W'(init_tag(int'(i)));
            end
            r_rptr  <= '0;
            r_wptr  <= FULL_CNT;
            r_count <= FULL_CNT;
        end else begin
            if (w_we_a) r_mem[w_waddr_a] <= w_wdata_a;
            if (w_we_b) r_mem[w_waddr_b] <= w_wdata_b;
            r_rptr  <= r_rptr + {{TAG_W{1'b0}}, w_rd_acc};
            r_wptr  <= r_wptr + {{(TAG_W-1){1'b0}}, w_ret_acc};
            r_count <= r_count + {{(TAG_W-1){1'b0}}, w_ret_acc} - {{TAG_W{1'b0}}, w_rd_acc};
        end
    end

    // Error is sticky across flush; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (!Flush && w_drop) begin
            r_err <= 1'b1;
        end
    end

`ifdef TAG_FREELIST_DUPCHK_EN
    always_ff @(posedge clock) begin
        if (reset || Flush) begin
            r_in_use <= '0;
        end else begin
            if (w_rd_acc) r_in_use[Tag_Out]   <= 1'b1;
            if (w_we_a)   r_in_use[w_wdata_a] <= 1'b0;
            if (w_we_b)   r_in_use[w_wdata_b] <= 1'b0;
        end
    end
`endif

    assign Tag_Out        = r_mem[r_rptr[TAG_W-1:0]];
    assign tagFifo_empty  = (r_count == '0);
    assign Tag_Valid      = ~tagFifo_empty;
    assign tagFifo_full   = (r_count == FULL_CNT);
    assign tagFifo_aempty = (r_count <= AE_CNT);
    assign tagFifo_count  = r_count;
    assign tagFifo_err    = r_err;

endmodule

// File: doc/tag_freelist.md
Name: tag_freelist

Overview:
- Parametrised successor to the single-port tag FIFO: a free list that hands out rename tags to dispatch and takes back retired tags.
- Supports configurable tag count, two retire ports per cycle, an occupancy count, an almost-empty flag, and a one-cycle flush that refills the list.
- Sits between the dispatch unit, which reads tags, and the Retire Bus, which returns them.

Parameters:
- TAG_W, 5, tag width in bits; NUM_TAGS = 2**TAG_W.
- AEMPTY_THRESH, 2, tagFifo_aempty asserts when count <= this value; legal range 0..NUM_TAGS-1.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Flush  in  1  branch-recovery refill; restores the full list.
- Rd_en  in  1  dispatch consumes Tag_Out this cycle.
- Tag_Out  out  TAG_W  tag at the read pointer (combinational from state).
- Tag_Valid  out  1  equals !tagFifo_empty.
- RB_Tag0  in  TAG_W  retire port 0 tag.
- RB_Tag0_Valid  in  1  retire port 0 valid.
- RB_Tag1  in  TAG_W  retire port 1 tag.
- RB_Tag1_Valid  in  1  retire port 1 valid.
- tagFifo_full  out  1  count == NUM_TAGS.
- tagFifo_empty  out  1  count == 0.
- tagFifo_aempty  out  1  count <= AEMPTY_THRESH.
- tagFifo_count  out  TAG_W+1  number of free tags.
- tagFifo_err  out  1  sticky; set when a retire is dropped.

Behaviour:
- Storage and pointers:
  - NUM_TAGS x TAG_W register array.
  - rptr and wptr are TAG_W+1 bits wide; the index is the low TAG_W bits, and the MSB is the wrap bit.
  - count is TAG_W+1 bits; all arithmetic is modulo 2**(TAG_W+1).
- Reset (reset=1 at the clock edge):
  - mem[i] = i for all i; rptr = 0; wptr = NUM_TAGS (MSB set, index 0); count = NUM_TAGS; err = 0.
  - Resulting outputs: Tag_Out = 0, Tag_Valid = 1, full = 1, empty = 0, aempty = 0, count = NUM_TAGS.
  - Reset overrides Flush, Rd_en and both retire ports in the same cycle.
- Flush (reset=0, Flush=1):
  - Same state as reset except err is held.
  - Rd_en and retires in that cycle are ignored.
- Read:
  - rd_acc = Rd_en & !empty, evaluated on start-of-cycle state.
  - rd_acc increments rptr; Tag_Out shows the next tag in the following cycle.
  - Rd_en while empty is ignored and does not set err.
  - No bypass from retire to read: a tag retired in cycle N is readable no earlier than cycle N+1.
- Retire:
  - space = NUM_TAGS - count, evaluated at the start of the cycle. The same-cycle read is not credited.
  - Port 0 has priority over port 1.
  - Accepted writes go to mem[wptr], then mem[wptr+1] when both ports are accepted.
  - wptr advances by the number of accepted writes (0, 1 or 2).
  - A valid retire that exceeds space is dropped and sets err.
    - space = 1 with both ports valid: port 0 is written, port 1 is dropped, err = 1.
    - space = 0: any valid retire is dropped.
- Count update: count_next = count + ret_acc - rd_acc, where ret_acc is 0..2.
  - Read and retire in the same cycle are legal.
  - count == NUM_TAGS with Rd_en=1 and one retire: the read is accepted and the retire is dropped (space = 0).
- Flags are derived combinationally from count.
  - All outputs follow registered state; no input-to-output combinational path exists except none (Tag_Out is from mem/rptr only).
- Latency: one cycle from accept to visible pointer or count change.

Optional Feature:
- Macro: TAG_FREELIST_DUPCHK_EN.
- When defined:
  - Adds a NUM_TAGS-bit in_use bitmap: reset and Flush clear it, an accepted read sets in_use[Tag_Out], and an accepted retire clears in_use[tag].
  - A valid retire of a tag whose in_use bit is 0 (double free) is dropped without consuming space and sets err.
  - When both ports carry the same tag in one cycle, port 1 is treated as a duplicate.
- When undefined:
  - No bitmap is present; retires are accepted purely on space.

Decomposition:
- Shared package holds:
  - TAG_W default and NUM_TAGS derivation.
  - A tag_t typedef of TAG_W bits and a cnt_t typedef of TAG_W+1 bits.
  - The function computing the reset or flush init value for index i.
- One sub-module, tag_freelist_wrctl, is natural: it contains the two-port accept/priority logic and produces ret_acc, the write enables, the write addresses and the drop pulse.

Test Plan:
- Reset, then 32 consecutive Rd_en with no retires -> Tag_Out sequence 0..31, empty=1 after the 32nd, count=0, aempty=1 from count 2 onward.
- Empty list, retire 7 on port 0 and 9 on port 1 in one cycle -> count=2 next cycle, Tag_Out=7, then 9 after one read.
- count=31 (after one read), both ports valid with tags 0 and 5 -> tag 0 is accepted, count=32, err=1, tag 5 is absent.
- Full list, Rd_en=1 plus port 0 retire -> read is accepted, retire is dropped, count=31, err=1.
- Mid-stream (count=10, wptr wrapped), Flush=1 with Rd_en=1 and a retire -> next cycle count=32, Tag_Out=0, err unchanged.
- With TAG_FREELIST_DUPCHK_EN: reset, then retire tag 3 (never allocated) -> retire is dropped, count stays 32, err=1; allocate 0, retire 0 twice on ports 0 and 1 -> one write, err=1.
